wb_arb: RTL and testbench

//  Round-robin Wishbone arbiter sharing one register slave (the software-register wb_host block) between NM masters.

---
 rtl/wb_arb_pkg.sv | 7 +
 rtl/wb_arb_rr.sv | 27 ++
 rtl/wb_arb.sv | 150 +++++++++++++++
 tb/tb_wb_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the wb_arb round-robin Wishbone arbiter.
package wb_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_st_t;
   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = 4;
endpackage

// File: rtl/wb_arb_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NM.
module wb_arb_rr #(
   parameter int NM = 2,
   parameter int PW = 1
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NM-1:0] gnt,
   output logic          any
);
   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      any   = |req;
      for (int i = 1; i <= NM; i++) begin
         idx = PW'((int'(ptr) + i) % NM);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_arb.sv
// Round-robin Wishbone arbiter, NM masters onto one slave, grant locked while cyc is held.
// Optional slave timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb
   import wb_arb_pkg::*;
#(
   parameter int NM      = 2,
   parameter int TMO_CYC = 255
) (
   input  logic                wbm_clk_i,
   input  logic                wbm_rst_n,
   input  logic [NM-1:0]       m_cyc_i,
   input  logic [NM-1:0]       m_stb_i,
   input  logic [NM*WB_AW-1:0] m_adr_i,
   input  logic [NM-1:0]       m_we_i,
   input  logic [NM*WB_DW-1:0] m_dat_i,
   input  logic [NM*WB_SW-1:0] m_sel_i,
   output logic [WB_DW-1:0]    m_dat_o,
   output logic [NM-1:0]       m_ack_o,
   output logic [NM-1:0]       m_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic [WB_AW-1:0]    s_adr_o,
   output logic                s_we_o,
   output logic [WB_DW-1:0]    s_dat_o,
   output logic [WB_SW-1:0]    s_sel_o,
   input  logic [WB_DW-1:0]    s_dat_i,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   output logic [NM-1:0]       gnt_o
);
   localparam int PW = (NM > 1) ? $clog2(NM) : 1;

   generate
      if (NM < 2 || NM > 8 || TMO_CYC < 1) begin : g_bad_param
         $error("wb_arb: NM must be 2..8 and TMO_CYC >= 1");
      end
   endgenerate

   arb_st_t           st, st_nx;
   logic [NM-1:0]     gnt, gnt_nx, pick;
   logic [PW-1:0]     ptr, ptr_nx, gidx, gidx_nx, pidx;
   logic              any, busy, tmo_hit;
   logic              g_cyc, g_stb, g_we;
   logic [WB_AW-1:0]  g_adr;
   logic [WB_DW-1:0]  g_dat;
   logic [WB_SW-1:0]  g_sel;

   wb_arb_rr #(.NM(NM), .PW(PW)) u_rr (
      .req (m_cyc_i & m_stb_i),
      .ptr (ptr),
      .gnt (pick),
      .any (any)
   );

   always_comb begin
      pidx = '0;
      for (int k = 0; k < NM; k++)
         if (pick[k]) pidx = PW'(k);
   end

   always_ff @(posedge wbm_clk_i) begin
      if (!wbm_rst_n) begin
         st   <= ARB_IDLE;
         gnt  <= '0;
         ptr  <= PW'(NM - 1);
         gidx <= '0;
      end else begin
         st   <= st_nx;
         gnt  <= gnt_nx;
         ptr  <= ptr_nx;
         gidx <= gidx_nx;
      end
   end

   // Release always passes through IDLE, so no same-cycle re-grant.
   always_comb begin
      st_nx   = st;
      gnt_nx  = gnt;
      ptr_nx  = ptr;
      gidx_nx = gidx;
      case (st)
         ARB_IDLE: if (any) begin
            st_nx   = ARB_BUSY;
            gnt_nx  = pick;
            gidx_nx = pidx;
         end
         ARB_BUSY: if (!g_cyc) begin
            st_nx  = ARB_IDLE;
            gnt_nx = '0;
            ptr_nx = gidx;
         end
         default: st_nx = ARB_IDLE;
      endcase
   end

   // One-hot AND-OR mux; grant is zero in IDLE so every s_* field reads 0.
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_we  = 1'b0;
      g_adr = '0;
      g_dat = '0;
      g_sel = '0;
      for (int k = 0; k < NM; k++) begin
         if (gnt[k]) begin
            g_cyc = m_cyc_i[k];
            g_stb = m_stb_i[k];
            g_we  = m_we_i[k];
            g_adr = m_adr_i[k*WB_AW +: WB_AW];
            g_dat = m_dat_i[k*WB_DW +: WB_DW];
            g_sel = m_sel_i[k*WB_SW +: WB_SW];
         end
      end
   end

   assign busy = (st == ARB_BUSY);

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);
   logic [CW-1:0] tmo_cnt;
   logic          stall;

   assign stall   = busy & g_cyc & g_stb & ~s_ack_i & ~s_err_i;
   assign tmo_hit = stall & (tmo_cnt == CW'(TMO_CYC - 1));

   always_ff @(posedge wbm_clk_i) begin
      if (!wbm_rst_n)
         tmo_cnt <= '0;
      else if (!busy || !g_cyc || s_ack_i || s_err_i || tmo_hit)
         tmo_cnt <= '0;
      else if (g_stb)
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign s_cyc_o = g_cyc;
   assign s_stb_o = g_cyc & g_stb & ~tmo_hit;
   assign s_adr_o = g_adr;
   assign s_we_o  = g_we;
   assign s_dat_o = g_dat;
   assign s_sel_o = g_sel;

   // Gating with the granted cyc discards a late ack after the master has given up.
   assign m_ack_o = gnt & {NM{g_cyc & s_ack_i & ~s_err_i}};
   assign m_err_o = gnt & {NM{g_cyc & (s_err_i | tmo_hit)}};
   assign m_dat_o = busy ? s_dat_i : '0;
   assign gnt_o   = gnt;
endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb; ack/err responses are checked by a queue-based monitor.
module tb_wb_arb;
   localparam int NM = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
   logic [NM*32-1:0]  m_adr = '0, m_dat = '0;
   logic [NM*4-1:0]   m_sel = '0;
   logic [31:0]       m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]        s_sel_o;
   logic              s_ack_i, s_err_i;
   logic              ack_en = 1'b1, err_en = 1'b0, ack_force = 1'b0;

   always #5 clk = ~clk;

   // Zero-wait slave: read data is a fixed tag OR'd with the address.
   assign s_ack_i = (s_cyc_o & s_stb_o & ack_en) | ack_force;
   assign s_err_i = s_cyc_o & s_stb_o & err_en;
   assign s_dat_i = 32'hA5A5_0000 | s_adr_o;

   wb_arb #(.NM(NM), .TMO_CYC(8)) dut (
      .wbm_clk_i(clk), .wbm_rst_n(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_we_i(m_we),
      .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o),
      .s_we_o(s_we_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
   );

   typedef struct {
      logic [NM-1:0] ack;
      logic [NM-1:0] err;
      logic [31:0]   dat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(negedge clk) begin
      if ((m_ack_o | m_err_o) != '0) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: ack %b err %b dat %h, no response expected",
                     m_ack_o, m_err_o, m_dat_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (m_ack_o !== mon_e.ack || m_err_o !== mon_e.err || m_dat_o !== mon_e.dat) begin
               n_fail++;
               $display("FAIL resp: got ack %b err %b dat %h, expected ack %b err %b dat %h",
                        m_ack_o, m_err_o, m_dat_o, mon_e.ack, mon_e.err, mon_e.dat);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr);
      m_cyc[m] = cyc;
      m_stb[m] = stb;
      m_we[m]  = we;
      m_adr[m*32 +: 32] = adr;
      m_dat[m*32 +: 32] = adr ^ 32'h0000_1234;
      m_sel[m*4 +: 4]   = 4'hF;
   endtask

   task automatic push(input logic [NM-1:0] a, input logic [NM-1:0] e, input logic [31:0] d);
      exp_t x;
      x.ack = a;
      x.err = e;
      x.dat = d;
      exp_q.push_back(x);
   endtask

   task automatic do_reset;
      set_m(0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0);
      ack_en = 1'b1; err_en = 1'b0; ack_force = 1'b0;
      rst_n = 1'b0;
      tick; tick;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with m0 already requesting
      set_m(0, 1, 1, 0, 32'h0);
      rst_n = 1'b0;
      tick; tick;
      chk("rst_gnt", 32'(gnt_o), 32'h0);
      chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
      chk("rst_s_stb", 32'(s_stb_o), 32'h0);
      chk("rst_s_adr", s_adr_o, 32'h0);
      chk("rst_ack", 32'(m_ack_o), 32'h0);
      chk("rst_dat", m_dat_o, 32'h0);
      push(2'b01, 2'b00, 32'hA5A5_0000);
      rst_n = 1'b1;
      tick;
      chk("m0_gnt", 32'(gnt_o), 32'h1);
      chk("m0_s_cyc", 32'(s_cyc_o), 32'h1);
      tick;
      set_m(0, 0, 0, 0, 0);
      tick;
      chk("m0_release", 32'(gnt_o), 32'h0);

      // Simultaneous requests: m0 first, one idle clock, then m1
      do_reset;
      set_m(0, 1, 1, 0, 32'h10);
      set_m(1, 1, 1, 0, 32'h20);
      push(2'b01, 2'b00, 32'hA5A5_0010);
      push(2'b10, 2'b00, 32'hA5A5_0020);
      tick;
      chk("rr_gnt_a", 32'(gnt_o), 32'h1);
      tick;
      set_m(0, 0, 0, 0, 0);
      chk("rr_gnt_hold", 32'(gnt_o), 32'h1);
      tick;
      chk("rr_gnt_idle", 32'(gnt_o), 32'h0);
      tick;
      chk("rr_gnt_b", 32'(gnt_o), 32'h2);
      tick;
      set_m(1, 0, 0, 0, 0);
      tick; tick;

      // Locked tenure: three writes by m0 while m1 waits
      do_reset;
      set_m(0, 1, 1, 1, 32'h0);
      set_m(1, 1, 1, 0, 32'h30);
      push(2'b01, 2'b00, 32'hA5A5_0000);
      push(2'b01, 2'b00, 32'hA5A5_0004);
      push(2'b01, 2'b00, 32'hA5A5_0000);
      push(2'b10, 2'b00, 32'hA5A5_0030);
      tick;
      chk("lock_gnt", 32'(gnt_o), 32'h1);
      chk("lock_s_adr", s_adr_o, 32'h0);
      chk("lock_s_we", 32'(s_we_o), 32'h1);
      chk("lock_s_dat", s_dat_o, 32'h0000_1234);
      chk("lock_s_sel", 32'(s_sel_o), 32'hF);
      tick;
      set_m(0, 1, 1, 1, 32'h4);
      #1 chk("lock_s_adr2", s_adr_o, 32'h4);
      tick;
      set_m(0, 1, 1, 1, 32'h0);
      tick;
      set_m(0, 1, 0, 1, 32'h0);
      #1 chk("lock_m1_wait", 32'(m_ack_o), 32'h0);
      chk("lock_gnt_held", 32'(gnt_o), 32'h1);
      tick;
      set_m(0, 0, 0, 0, 0);
      tick;
      chk("lock_idle", 32'(gnt_o), 32'h0);
      tick;
      chk("lock_m1_gnt", 32'(gnt_o), 32'h2);
      tick;
      set_m(1, 0, 0, 0, 0);
      tick; tick;

      // m1 ack routing, then ack+err together
      do_reset;
      set_m(1, 1, 1, 0, 32'h40);
      push(2'b10, 2'b00, 32'hA5A5_0040);
      tick;
      chk("m1_gnt", 32'(gnt_o), 32'h2);
      chk("m1_ack", 32'(m_ack_o), 32'h2);
      tick;
      set_m(1, 1, 1, 0, 32'h44);
      err_en = 1'b1;
      push(2'b00, 2'b10, 32'hA5A5_0044);
      #1 chk("err_wins_err", 32'(m_err_o), 32'h2);
      chk("err_wins_ack", 32'(m_ack_o), 32'h0);
      tick;
      set_m(1, 0, 0, 0, 0);
      err_en = 1'b0;
      tick; tick;

      // Master drops cyc mid-transfer; late slave ack must not reach it
      do_reset;
      ack_en = 1'b0;
      set_m(0, 1, 1, 0, 32'h60);
      tick;
      chk("drop_s_stb_before", 32'(s_stb_o), 32'h1);
      set_m(0, 0, 0, 0, 32'h60);
      ack_force = 1'b1;
      #1 chk("drop_s_cyc", 32'(s_cyc_o), 32'h0);
      chk("drop_s_stb", 32'(s_stb_o), 32'h0);
      chk("drop_late_ack", 32'(m_ack_o), 32'h0);
      tick;
      ack_force = 1'b0;
      tick; tick;

      // Hung slave: timeout error on the 8th stalled clock when enabled
      do_reset;
      ack_en = 1'b0;
      set_m(0, 1, 1, 0, 32'h50);
`ifdef WB_ARB_TIMEOUT_EN
      push(2'b00, 2'b01, 32'hA5A5_0050);
`endif
      tick;
      for (int k = 1; k <= 9; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
         chk($sformatf("tmo_err_%0d", k), 32'(m_err_o), (k == 8) ? 32'h1 : 32'h0);
         chk($sformatf("tmo_stb_%0d", k), 32'(s_stb_o), (k == 8) ? 32'h0 : 32'h1);
`else
         chk($sformatf("stall_err_%0d", k), 32'(m_err_o), 32'h0);
         chk($sformatf("stall_stb_%0d", k), 32'(s_stb_o), 32'h1);
`endif
         tick;
      end
      set_m(0, 0, 0, 0, 0);
      tick; tick;

      // Reset during BUSY restores pointer so m0 wins next
      do_reset;
      ack_en = 1'b0;
      set_m(1, 1, 1, 0, 32'h70);
      tick;
      chk("midrst_m1_gnt", 32'(gnt_o), 32'h2);
      rst_n = 1'b0;
      set_m(0, 1, 1, 0, 32'h74);
      tick;
      chk("midrst_gnt", 32'(gnt_o), 32'h0);
      chk("midrst_s_cyc", 32'(s_cyc_o), 32'h0);
      rst_n = 1'b1;
      tick;
      chk("midrst_m0_wins", 32'(gnt_o), 32'h1);
      set_m(0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0);
      tick; tick; tick;

      chk("resp_queue_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
